stream_demux: RTL

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux_pkg.sv | 11 +
 rtl/stream_demux_if.sv | 15 +
 rtl/demux_slot.sv | 52 +++++
 rtl/stream_demux.sv | 72 +++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants for the two-channel stream demultiplexer.
// Holds default widths and the channel-index encodings used by src_sel.
package stream_demux_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 8;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/stream_demux_if.sv
// Valid/ready/data stream bundle; master drives valid+data, slave drives ready.
interface stream_demux_if
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/demux_slot.sv
// One output slot of the demux: single-entry buffer with EMPTY/FULL control
// and a wrapping count of beats delivered downstream.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             can_take,
    output logic [CNT_W-1:0] cnt,
    stream_demux_if.master   res
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             deliver;

    assign deliver  = (state_reg == FULL) && res.ready;
    // A full slot can still take a beat in the same cycle it hands one off.
    assign can_take = (state_reg == EMPTY) || deliver;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= EMPTY;
            data_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            if (load) begin
                state_reg <= FULL;
                data_reg  <= load_data;
            end else if (deliver) begin
                state_reg <= EMPTY;
            end
            if (deliver) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign res.valid = (state_reg == FULL);
    assign res.data  = data_reg;
    assign cnt       = cnt_reg;

endmodule

// File: rtl/stream_demux.sv
// Routes each accepted source beat to one of two buffered output channels;
// the top only decodes src_sel and muxes the selected slot's readiness.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] src_data,
    input  logic             src_sel,
    output logic             res0_valid,
    input  logic             res0_ready,
    output logic [WIDTH-1:0] res0_data,
    output logic [CNT_W-1:0] res0_cnt,
    output logic             res1_valid,
    input  logic             res1_ready,
    output logic [WIDTH-1:0] res1_data,
    output logic [CNT_W-1:0] res1_cnt
);

    logic [1:0]       res_ready;
    logic [1:0]       can_take;
    logic [1:0]       load;
    logic [1:0]       slot_valid;
    logic [WIDTH-1:0] slot_data [2];
    logic [CNT_W-1:0] slot_cnt  [2];
    logic             accept;

    assign res_ready = {res1_ready, res0_ready};
    assign src_ready = can_take[src_sel];
    assign accept    = src_valid && src_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            localparam logic CH = (gi == 0) ? CH0 : CH1;

            stream_demux_if #(.WIDTH(WIDTH)) ch ();

            assign ch.ready       = res_ready[gi];
            assign slot_valid[gi] = ch.valid;
            assign slot_data[gi]  = ch.data;
            // Only the selected slot is ever written.
            assign load[gi]       = accept && (src_sel == CH);

            demux_slot #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_slot (
                .clk       (clk),
                .rstn      (rstn),
                .load      (load[gi]),
                .load_data (src_data),
                .can_take  (can_take[gi]),
                .cnt       (slot_cnt[gi]),
                .res       (ch)
            );
        end
    endgenerate

    assign res0_valid = slot_valid[0];
    assign res0_data  = slot_data[0];
    assign res0_cnt   = slot_cnt[0];
    assign res1_valid = slot_valid[1];
    assign res1_data  = slot_data[1];
    assign res1_cnt   = slot_cnt[1];

endmodule
